// File: rtl/vga_text_ram_arbiter_pkg.sv
// Shared text-mode geometry and arbiter state encoding for the VGA text path.
// The sync generator imports the same constants.
package vga_text_ram_arbiter_pkg;

    localparam int TEXT_COLS  = 80;
    localparam int TEXT_ROWS  = 30;
    localparam int CELL_W     = 8;
    localparam int CELL_H     = 16;
    localparam int RAM_ADDR_W = 12;
    localparam int CHAR_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISP_RD   = 3'd1,
        ST_DISP_WAIT = 3'd2,
        ST_CPU_ACC   = 3'd3,
        ST_CPU_WAIT  = 3'd4
    } arb_state_t;

    // States after which the RAM port is free in the following cycle.
    function automatic logic is_decision(arb_state_t s);
        return (s == ST_IDLE) || (s == ST_DISP_WAIT) || (s == ST_CPU_WAIT);
    endfunction

endpackage

// File: rtl/vga_text_ram_arbiter_cell_addr.sv
// Combinational text-cell address: row*COLS + col, using shift-add for 80 columns.
module vga_text_ram_arbiter_cell_addr #(
    parameter int COLS   = 80,
    parameter int ADDR_W = 12
) (
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] cell_addr
);

    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] col_ext;
    logic [ADDR_W-1:0] row_base;

    assign row_ext = ADDR_W'(row);
    assign col_ext = ADDR_W'(col);

    if (COLS == 80) begin : g_shift_add
        // 80 = 64 + 16
        assign row_base = (row_ext << 6) + (row_ext << 4);
    end else begin : g_mul
        assign row_base = ADDR_W'(32'(row) * COLS);
    end

    assign cell_addr = row_base + col_ext;

endmodule

// File: rtl/vga_text_ram_arbiter.sv
// Arbitrates the single-port text RAM between display character fetches
// (absolute priority) and CPU req/ack accesses in free RAM cycles.
module vga_text_ram_arbiter
    import vga_text_ram_arbiter_pkg::*;
#(
    parameter int COLS   = TEXT_COLS,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = CHAR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] char_code,
    output logic              char_valid
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              fetch;
    logic              disp_pend;
    logic [ADDR_W-1:0] cell_addr;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              acc_we;
    logic              unused_pix_bits;

    logic              ram_en_d;
    logic              ram_we_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d;

    vga_text_ram_arbiter_cell_addr #(
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_cell_addr (
        .row       (pixel_y[8:4]),
        .col       (pixel_x[9:3]),
        .cell_addr (cell_addr)
    );

    assign unused_pix_bits = ^{pixel_y[9], pixel_y[3:0]};

    assign fetch = pix_tick & video_on & (pixel_x[2:0] == 3'd0);

    // A fetch raised while the CPU owns the port is replayed from disp_addr.
    assign fetch_addr = fetch ? cell_addr : disp_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        if (is_decision(state)) begin
            if (disp_pend || fetch) begin
                state_next = ST_DISP_RD;
            end else if (cpu_req && !cpu_ack && !pix_tick && (state != ST_CPU_WAIT)) begin
                state_next = ST_CPU_ACC;
            end else begin
                state_next = ST_IDLE;
            end
        end else begin
            case (state)
                ST_DISP_RD: state_next = ST_DISP_WAIT;
                ST_CPU_ACC: state_next = ST_CPU_WAIT;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Port controls are computed for the upcoming state and registered,
    // so the RAM pins follow the state register exactly.
    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        case (state_next)
            ST_DISP_RD: begin
                ram_en_d   = 1'b1;
                ram_addr_d = fetch_addr;
            end
            ST_CPU_ACC: begin
                ram_en_d    = 1'b1;
                ram_we_d    = cpu_we;
                ram_addr_d  = cpu_addr;
                ram_wdata_d = cpu_wdata;
            end
            default: begin
                ram_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en    <= ram_en_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_pend <= 1'b0;
            disp_addr <= '0;
        end else begin
            if (state_next == ST_DISP_RD) disp_pend <= 1'b0;
            else if (fetch)               disp_pend <= 1'b1;
            if (fetch) disp_addr <= cell_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            char_valid <= 1'b0;
            char_code  <= '0;
        end else begin
            if (state_next == ST_CPU_ACC) acc_we <= cpu_we;
            cpu_ack    <= (state == ST_CPU_WAIT);
            char_valid <= (state == ST_DISP_WAIT);
            if (state == ST_DISP_WAIT)           char_code <= ram_rdata;
            if (state == ST_CPU_WAIT && !acc_we) cpu_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_vga_text_ram_arbiter.sv
// Bench for the text RAM arbiter: directed timing steps, then a randomized
// scan of several text lines against continuous CPU traffic.
module tb_vga_text_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [7:0]  char_code;
    logic        char_valid;

    always #5 clk = ~clk;

    vga_text_ram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .pix_tick  (pix_tick),
        .video_on  (video_on),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .char_code (char_code),
        .char_valid(char_valid)
    );

    // Single-port RAM with 1-cycle read latency, plus a bench-side load port.
    logic [7:0]  mem [4096];
    logic        load_en = 1'b0;
    logic [11:0] load_addr = '0;
    logic [7:0]  load_data = '0;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    logic [7:0] ref_mem [4096];
    logic [7:0] exp_q [$];
    int checks = 0;
    int failures = 0;
    int fetches_exp = 0;
    int cv_count = 0;
    int ack_count = 0;
    int n_req = 0;
    bit scan_done = 0;
    bit cpu_done = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] cell_of(input int x, input int y);
        return 12'((y / 16) * 80 + x / 8);
    endfunction

    task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd);
        int lat;
        logic got;
        lat = 0;
        got = 1'b0;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        while (!got && lat < 12) begin
            step();
            lat++;
            got = cpu_ack;
        end
        rd = cpu_rdata;
        checks++;
        assert (got && lat >= 3 && lat <= 6) else begin
            failures++;
            $error("FAIL cpu_ack_latency observed=%0d got=%0d expected=3..6", lat, got);
        end
        if (got && we) ref_mem[addr] = wd;
        step();
        cpu_req = 1'b0;
    endtask

    task automatic scan_line(input int y);
        for (int x = 0; x < 800; x++) begin
            for (int s = 0; s < 4; s++) begin
                pixel_x = 10'(x);
                pixel_y = 10'(y);
                video_on = (x < 640) && (y < 480);
                pix_tick = (s == 0);
                if (pix_tick && video_on && (x % 8 == 0)) begin
                    exp_q.push_back(ref_mem[cell_of(x, y)]);
                    fetches_exp++;
                end
                step();
            end
        end
        pix_tick = 1'b0;
        video_on = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] v;
        int bad;

        // Preload RAM and reference while reset is held.
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            if (i == 162) v = 8'h41;
            if (i == 244) v = 8'h99;
            ref_mem[i] = v;
            load_addr = 12'(i);
            load_data = v;
            load_en = 1'b1;
            step();
        end
        load_en = 1'b0;
        step();
        chk("reset_outputs",
            {ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_rdata, char_valid, char_code}, 64'd0);
        reset = 1'b0;
        step();

        // Reset in the middle of a CPU access drops it; the held request is re-served.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'hC3;
        step();
        chk("acc_before_reset", {ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 12'h010});
        reset = 1'b1;
        #2;
        chk("reset_mid_acc_outputs",
            {ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_rdata, char_valid, char_code}, 64'd0);
        step();
        reset = 1'b0;
        chk("post_reset_no_ack", cpu_ack, 1'b0);
        step();
        chk("reissue_ram_en", {ram_en, cpu_ack, ram_addr}, {1'b1, 1'b0, 12'h010});
        step();
        chk("reissue_no_ack_yet", cpu_ack, 1'b0);
        step();
        chk("reissue_ack", cpu_ack, 1'b1);
        ref_mem[12'h010] = 8'hC3;
        step();
        cpu_req = 1'b0;

        // Display fetch at pixel (16,32).
        step();
        pix_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd16; pixel_y = 10'd32;
        step();
        pix_tick = 1'b0;
        chk("disp_rd_t1", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, cell_of(16, 32)});
        step();
        chk("disp_no_valid_t2", char_valid, 1'b0);
        step();
        chk("disp_valid_t3", {char_valid, char_code}, {1'b1, ref_mem[cell_of(16, 32)]});
        video_on = 1'b0;

        // CPU write then read in blanking.
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h100; cpu_wdata = 8'h5A;
        step();
        chk("cpu_wr_port_c1", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 12'h100, 8'h5A});
        step();
        chk("cpu_wr_no_ack_c2", cpu_ack, 1'b0);
        step();
        chk("cpu_wr_ack_c3", cpu_ack, 1'b1);
        ref_mem[12'h100] = 8'h5A;
        step();
        cpu_req = 1'b0;
        cpu_access(1'b0, 12'h100, 8'h00, rd);
        chk("cpu_rd_0x100", rd, ref_mem[12'h100]);

        // Request rising on a fetch tick: display wins.
        step();
        pix_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd24; pixel_y = 10'd32;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h100;
        step();
        pix_tick = 1'b0;
        chk("tie_disp_t1", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, cell_of(24, 32)});
        step();
        chk("tie_idle_t2", ram_en, 1'b0);
        step();
        chk("tie_cpu_t3", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 12'h100});
        chk("tie_char_t3", {char_valid, char_code}, {1'b1, ref_mem[cell_of(24, 32)]});
        step();
        step();
        chk("tie_ack_t5", {cpu_ack, cpu_rdata}, {1'b1, ref_mem[12'h100]});
        step();
        cpu_req = 1'b0;
        video_on = 1'b0;

        // Tick arriving while the CPU owns the port.
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h77;
        step();
        chk("late_cpu_acc", {ram_en, ram_we}, 2'b11);
        pix_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd32; pixel_y = 10'd48;
        step();
        pix_tick = 1'b0;
        chk("late_t1_idle", ram_en, 1'b0);
        step();
        chk("late_t2_disp", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, cell_of(32, 48)});
        chk("late_t2_ack", cpu_ack, 1'b1);
        step();
        cpu_req = 1'b0;
        ref_mem[12'h200] = 8'h77;
        chk("late_t3_no_valid", char_valid, 1'b0);
        step();
        chk("late_t4_char", {char_valid, char_code}, {1'b1, ref_mem[cell_of(32, 48)]});
        video_on = 1'b0;
        cpu_access(1'b0, 12'h200, 8'h00, rd);
        chk("late_cpu_data_intact", rd, 8'h77);

        // Scan text row 5 plus a blanking line against continuous CPU traffic.
        fork
            begin : scanner
                for (int y = 80; y < 88; y++) scan_line(y);
                scan_line(480);
                scan_done = 1;
            end
            begin : writer
                logic        w_we;
                logic [11:0] w_addr;
                logic [7:0]  w_data;
                logic [7:0]  w_exp;
                logic [7:0]  w_rd;
                while (!scan_done) begin
                    w_we = ($urandom_range(0, 3) != 0);
                    w_addr = 12'($urandom_range(2400, 4095));
                    w_data = 8'($urandom);
                    w_exp = ref_mem[w_addr];
                    n_req++;
                    cpu_access(w_we, w_addr, w_data, w_rd);
                    if (!w_we) chk("scan_cpu_read", w_rd, w_exp);
                end
                cpu_done = 1;
            end
            begin : monitor
                int tail;
                tail = 0;
                while (tail < 10) begin
                    @(negedge clk);
                    if (char_valid) begin
                        cv_count++;
                        if (exp_q.size() > 0) chk("scan_char_code", char_code, exp_q.pop_front());
                    end
                    if (cpu_ack) ack_count++;
                    if (scan_done && cpu_done) tail++;
                end
            end
        join

        chk("scan_char_valid_count", cv_count, fetches_exp);
        chk("scan_fetches_per_rowband", fetches_exp, 8 * 80);
        chk("scan_cpu_ack_count", ack_count, n_req);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_ram_mismatches", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_text_ram_arbiter.md
# vga_text_ram_arbiter

Shares the single-port character (text) RAM between the VGA display fetch path and the PicoBlaze port interface. Runs on the 100 MHz system clock alongside the VGA sync generator and consumes its pixel tick, pixel_x/pixel_y and video-active outputs. Display fetches have absolute priority; CPU reads and writes use a req/ack handshake and are served in free RAM cycles. The fetched character code is passed to the font ROM stage.

## Interface
- COLS, 80, text columns (640/8)
- ROWS, 30, text rows (480/16)
- ADDR_W, 12, RAM address width
- DATA_W, 8, character code width
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high
- pix_tick  in  1  one-cycle strobe, once every 4 clk (25 MHz pixel rate)
- video_on  in  1  pixel inside 640x480 active area
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  CPU RAM address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_en
- char_code  out  DATA_W  last fetched character code
- char_valid  out  1  one-cycle pulse when char_code updates

## Operation
- Fetch condition: pix_tick & video_on & pixel_x[2:0]==0. Fetch address = pixel_y[8:4]*COLS + pixel_x[9:3]; y*80 computed as (y<<6)+(y<<4); max 29*80+79 = 2399.
- disp_pend: set on fetch condition; cleared on entering DISP_RD.
- FSM states: IDLE, DISP_RD, DISP_WAIT, CPU_ACC, CPU_WAIT.
- Decision states: IDLE, DISP_WAIT, CPU_WAIT (RAM free in next cycle). In a decision state:
  - disp_pend or fetch condition -> DISP_RD.
  - else cpu_req & !cpu_ack & !pix_tick & state!=CPU_WAIT -> CPU_ACC (latch cpu_we/addr/wdata).
  - else -> IDLE.
- DISP_RD: ram_en=1, ram_we=0, ram_addr=fetch address; -> DISP_WAIT.
- DISP_WAIT: char_code <= ram_rdata, char_valid=1 next cycle.
- CPU_ACC: ram_en=1, ram_we=latched we, addr/wdata from latch; -> CPU_WAIT.
- CPU_WAIT: cpu_rdata <= ram_rdata (reads; unchanged on writes); cpu_ack=1 next cycle.
- CPU not issued in the pix_tick cycle, so a CPU access never blocks a tick-cycle decision.
- CPU addresses >= COLS*ROWS are accessed normally; no error flag.

## Timing
- Reset (async, any state): state=IDLE, disp_pend=0, all outputs 0 (ram_en, ram_we, cpu_ack, char_valid, char_code, cpu_rdata, ram_addr, ram_wdata). In-flight CPU request is dropped; CPU re-issues.
- RAM outputs are registered and reflect the current state.
- Display: tick at T in a decision state -> ram_en T+1, char_valid T+3. Tick during CPU_ACC -> ram_en T+2, char_valid T+4. Downstream uses char_valid, not a fixed latency.
- CPU: decision at cycle c -> ram_en c+1, cpu_ack c+3. Best case req->ack 3 cycles; worst case 6 (display fetch in progress).
- Requester deasserts cpu_req in the cycle after cpu_ack. Requests are ignored during the ack cycle, so minimum spacing is 4 cycles per CPU access.
- Simultaneous fetch tick and cpu_req: display wins; CPU served at the next decision point.
- Blanking (video_on=0): no fetches; CPU gets every decision slot.

## Structure
- Shared header vga_params.vh holds COLS, ROWS, CELL_W=8, CELL_H=16 and the FSM state encodings (3-bit localparams). The sync generator uses the same header.
- One sub-module: vga_cell_addr, a combinational pixel_x/pixel_y -> cell address calculator (shift-add). Everything else is in the top.

## Test plan
- Reset mid CPU_ACC (cpu_req=1, addr 0x010) -> all outputs 0 next cycle, state IDLE, no cpu_ack until req re-seen.
- pix_tick with pixel_x=16, pixel_y=32, video_on=1, RAM[162]=0x41 -> ram_addr=162 at T+1, char_code=0x41 with char_valid at T+3.
- CPU write 0x5A to 0x100 in blanking, then read 0x100 -> write ack at c+3; read returns cpu_rdata=0x5A with ack.
- cpu_req rising on a fetch pix_tick cycle -> display read at T+1, CPU ram_en at T+3, cpu_ack at T+5.
- cpu_req held through CPU_ACC while a tick arrives -> display ram_en at T+2, char_valid at T+4, CPU data intact.
- Full frame with continuous CPU writes -> exactly 80*30*16 = 38400 char_valid pulses per frame; no CPU ack lost or duplicated; final RAM matches the written pattern.
